mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_MAX, 4, consecutive data grants allowed while a fetch waits (1..15).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request, held until i_ack or i_kill.
- i_addr  in  32  fetch word address.
- i_kill  in  1  pipeline redirect; cancels the outstanding fetch.
- i_ack  out  1  fetch response valid, one-cycle pulse.
- i_rdata  out  32  fetch instruction word.
- d_req  in  1  load/store request, held until d_ack.
- d_we  in  1  1 = store.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_ack  out  1  data response valid, one-cycle pulse.
- d_rdata  out  32  load data.
- m_req  out  1  memory request, held until m_ready.
- m_we  out  1  memory write.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_be  out  4  memory byte enables; 4'b1111 on fetches.
- m_ready  in  1  memory completes the current request this cycle.
- m_rdata  in  32  memory read data, valid with m_ready.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement states IDLE, BUSY_I, BUSY_D, RESP.
REQ-004 SHALL, in IDLE, arbitrate on the sampled d_req/i_req: data wins over fetch unless starve_cnt == STARVE_MAX with i_req high, in which case fetch wins.
REQ-005 SHALL, on a grant, register address, we, wdata and be from the winner into the m_* outputs; m_req SHALL be high starting the cycle after the request is sampled.
REQ-006 SHALL keep m_* outputs stable while m_req=1 and m_ready=0; there is no timeout.
REQ-007 SHALL, on m_ready in BUSY_x, deassert m_req, register m_rdata into x_rdata, and move to RESP; x_ack SHALL be high for exactly the RESP cycle.
REQ-008 SHALL return from RESP to IDLE unconditionally; requests are not sampled in RESP.
REQ-009 SHALL give a minimum latency of req at cycle 0 -> m_req cycle 1 -> (m_ready cycle 1) -> ack cycle 2 -> next arbitration cycle 3.
REQ-010 SHALL increment starve_cnt (saturating at STARVE_MAX) on each data grant made while i_req=1, and clear it on any fetch grant or when i_req=0 at arbitration.
REQ-011 SHALL, on i_kill while BUSY_I, let the memory transaction complete but suppress i_ack for it; i_kill SHALL be latched until completion.
REQ-012 SHALL ignore i_kill while in IDLE, BUSY_D, or RESP for a data response, and SHALL suppress i_ack when i_kill arrives in the RESP cycle of a fetch.
REQ-013 SHALL let x_rdata hold its last value when x_ack=0; store responses SHALL leave d_rdata unchanged.
REQ-014 SHALL grant data when d_req and i_req rise in the same cycle and starve_cnt < STARVE_MAX.

Reset
REQ-015 SHALL, while rst=1, force state IDLE, starve_cnt 0, kill latch 0, and m_req, m_we, i_ack, d_ack and busy to 0; m_addr, m_wdata, i_rdata and d_rdata SHALL be 32'h0 and m_be 4'h0.
REQ-016 SHALL, when rst is asserted mid-transaction, abandon it immediately with no ack, and SHALL arbitrate afresh after reset is released.

Verification
REQ-017 SHALL be covered by these scenarios:
- Single fetch: i_req, i_addr=0x100, m_ready on first m_req cycle, m_rdata=0x00500293 -> i_ack in cycle 2, i_rdata=0x00500293, m_be=4'b1111.
- Simultaneous requests: i_req and d_req together, d_we=1, d_addr=0x200 -> store granted first with m_we=1; fetch granted in the next arbitration.
- Starvation: d_req held high, i_req held high, STARVE_MAX=4 -> 4 data grants, then 1 fetch grant, then starve_cnt is 0.
- Kill: i_kill pulsed during BUSY_I with m_ready delayed 3 cycles -> no i_ack pulse, and busy returns to 0 after RESP.
- Wait states: m_ready low for 5 cycles -> m_addr/m_wdata stable throughout, ack in the cycle after m_ready.
- Reset mid-BUSY_D: rst asserted -> m_req=0 and busy=0 immediately, no d_ack pulse.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the arbiter and the memory port.
// The arbiter uses the slave view; the requester/memory side uses the master view.
interface mem_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_kill;
   logic        i_ack;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_ack;
   logic [31:0] d_rdata;

   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic        m_ready;
   logic [31:0] m_rdata;

   logic        busy;

   modport slave (
      input  i_req, i_addr, i_kill,
      output i_ack, i_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_be,
      output d_ack, d_rdata,
      output m_req, m_we, m_addr, m_wdata, m_be,
      input  m_ready, m_rdata,
      output busy
   );

   modport master (
      output i_req, i_addr, i_kill,
      input  i_ack, i_rdata,
      output d_req, d_we, d_addr, d_wdata, d_be,
      input  d_ack, d_rdata,
      input  m_req, m_we, m_addr, m_wdata, m_be,
      output m_ready, m_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port, data-priority with
// bounded fetch starvation and fetch cancellation on pipeline redirect.
//
// state  | meaning
// IDLE   | sampling d_req/i_req, grant registers the winner onto m_*
// BUSY_I | fetch in flight on memory, waiting for m_ready
// BUSY_D | load/store in flight on memory, waiting for m_ready
// RESP   | one-cycle response: ack pulse for the completed requester
module mem_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   mem_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] starve_cnt;
   logic       kill_q;
   logic       resp_i;
   logic       grant_i;
   logic       grant_d;
   logic       fetch_dead;

   always_comb begin
      grant_i = (state == IDLE) && bus.i_req &&
                ((starve_cnt == STARVE_LIM) || !bus.d_req);
      grant_d = (state == IDLE) && bus.d_req && !grant_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_i)      state_nxt = BUSY_I;
            else if (grant_d) state_nxt = BUSY_D;
         end
         BUSY_I: if (bus.m_ready) state_nxt = RESP;
         BUSY_D: if (bus.m_ready) state_nxt = RESP;
         RESP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.m_req = (state == BUSY_I) || (state == BUSY_D);
      bus.busy  = (state != IDLE);
      bus.i_ack = (state == RESP) && resp_i && !kill_q && !bus.i_kill;
      bus.d_ack = (state == RESP) && !resp_i;
   end

   // A redirect seen in the completing cycle counts as well as one latched earlier.
   assign fetch_dead = kill_q || bus.i_kill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.m_we    <= 1'b0;
         bus.m_addr  <= 32'h0;
         bus.m_wdata <= 32'h0;
         bus.m_be    <= 4'h0;
         bus.i_rdata <= 32'h0;
         bus.d_rdata <= 32'h0;
         starve_cnt  <= 4'd0;
         kill_q      <= 1'b0;
         resp_i      <= 1'b0;
      end else begin
         if (grant_i) begin
            bus.m_addr  <= bus.i_addr;
            bus.m_we    <= 1'b0;
            bus.m_wdata <= 32'h0;
            bus.m_be    <= 4'b1111;
            resp_i      <= 1'b1;
         end else if (grant_d) begin
            bus.m_addr  <= bus.d_addr;
            bus.m_we    <= bus.d_we;
            bus.m_wdata <= bus.d_wdata;
            bus.m_be    <= bus.d_be;
            resp_i      <= 1'b0;
         end

         if (state == IDLE) begin
            if (grant_i || !bus.i_req)
               starve_cnt <= 4'd0;
            else if (grant_d && (starve_cnt < STARVE_LIM))
               starve_cnt <= starve_cnt + 4'd1;
         end

         if ((state == BUSY_I) && bus.i_kill) kill_q <= 1'b1;
         else if (state == RESP)              kill_q <= 1'b0;

         if ((state == BUSY_I) && bus.m_ready && !fetch_dead)
            bus.i_rdata <= bus.m_rdata;
         if ((state == BUSY_D) && bus.m_ready && !bus.m_we)
            bus.d_rdata <= bus.m_rdata;
      end
   end

endmodule
